// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg: shared state encoding and default sizing for mem_arbiter.
// Revision: 1.0
// ============================================================================
package mem_arb_pkg;

  localparam int DEFAULT_DW         = 32;
  localparam int DEFAULT_AW         = 8;
  localparam int DEFAULT_STARVE_MAX = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter: shares one single-port RAM between an instruction-fetch port
// and a data port; data wins unless fetch has been starved STARVE_MAX cycles.
// Revision: 1.0
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW         = DEFAULT_DW,
  parameter int AW         = DEFAULT_AW,
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_valid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wren,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            CW           = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] c_starve_max = CW'(STARVE_MAX);

  arb_state_t    r_state;
  arb_state_t    w_state_next;
  logic [CW-1:0] r_starve_cnt;
  logic          w_force;
  logic          w_d_gnt;
  logic          w_i_gnt;

  // Fetch is promoted only once it has lost STARVE_MAX consecutive cycles.
  assign w_force = i_req && (r_starve_cnt == c_starve_max);
  assign w_d_gnt = d_req && !w_force;
  assign w_i_gnt = i_req && !w_d_gnt;

  assign i_gnt     = w_i_gnt;
  assign d_gnt     = w_d_gnt;
  assign mem_wren  = w_d_gnt && d_we;
  assign mem_wdata = d_wdata;
  assign mem_addr  = w_d_gnt ? d_addr : (w_i_gnt ? i_addr : '0);

  assign i_valid = (r_state == RD_I);
  assign d_valid = (r_state == RD_D);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_starve_cnt <= '0;
    end else if (!i_req || w_i_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != c_starve_max) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Writes complete on the grant cycle, so only reads schedule a response.
  always_comb begin
    w_state_next = IDLE;
    if (w_d_gnt && !d_we) begin
      w_state_next = RD_D;
    end else if (w_i_gnt) begin
      w_state_next = RD_I;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model of the arbitration and response rules.
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int SMAX = 3;

  logic          clock = 1'b0;
  logic          clear;
  logic          i_req, i_gnt, i_valid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_valid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SMAX)) dut (
    .clock    (clock),
    .clear    (clear),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_valid  (i_valid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_valid  (d_valid),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_wren (mem_wren),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: count of consecutive denied fetch cycles and the
  // responses owed on the next cycle.
  int m_denied = 0;
  bit m_known  = 1'b0;
  bit m_pend_i = 1'b0;
  bit m_pend_d = 1'b0;

  logic o_ig, o_dg, o_iv, o_dv, o_wren;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_irdata, o_drdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit clr, input bit ir, input logic [AW-1:0] ia,
                     input bit dr, input bit dwe, input logic [AW-1:0] da,
                     input logic [DW-1:0] dwd, input logic [DW-1:0] mrd);
    bit            e_force, e_dg, e_ig;
    logic [AW-1:0] e_addr;
    clear = clr; i_req = ir; i_addr = ia;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; mem_rdata = mrd;
    #2;
    e_force = ir && (m_denied >= SMAX);
    e_dg    = dr && !e_force;
    e_ig    = ir && !e_dg;
    e_addr  = e_dg ? da : (e_ig ? ia : '0);
    chk("d_gnt", d_gnt, e_dg);
    chk("i_gnt", i_gnt, e_ig);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wren", mem_wren, e_dg && dwe);
    chk("mem_wdata", mem_wdata, dwd);
    if (m_known) begin
      chk("i_valid", i_valid, m_pend_i);
      chk("d_valid", d_valid, m_pend_d);
    end
    if (m_pend_i) chk("i_rdata", i_rdata, mrd);
    if (m_pend_d) chk("d_rdata", d_rdata, mrd);
    o_ig = i_gnt; o_dg = d_gnt; o_iv = i_valid; o_dv = d_valid;
    o_wren = mem_wren; o_addr = mem_addr; o_irdata = i_rdata; o_drdata = d_rdata;
    if (clr) begin
      m_known = 1'b1; m_pend_i = 1'b0; m_pend_d = 1'b0; m_denied = 0;
    end else begin
      m_pend_i = e_ig;
      m_pend_d = e_dg && !dwe;
      m_denied = (ir && !e_ig) ? ((m_denied + 1 > SMAX) ? SMAX : m_denied + 1) : 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic [DW-1:0] mrd);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, mrd);
  endtask

  bit            r_ir, r_dr, r_dwe;
  logic [AW-1:0] r_ia, r_da;
  logic [DW-1:0] r_dwd;

  initial begin
    clear = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
    @(posedge clock);
    #1;
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    idle(32'h1234_5678);
    chk("rst_i_valid", o_iv, 1'b0);
    chk("rst_d_valid", o_dv, 1'b0);

    // Single instruction fetch, one cycle latency
    cyc(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, '0, '0, '0);
    chk("f1_i_gnt", o_ig, 1'b1);
    chk("f1_addr", o_addr, 8'h05);
    idle(32'h0010_0093);
    chk("f1_i_valid", o_iv, 1'b1);
    chk("f1_i_rdata", o_irdata, 32'h0010_0093);

    // Data read beats a simultaneous fetch; fetch follows
    cyc(1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'h10, '0, '0);
    chk("c_d_gnt", o_dg, 1'b1);
    chk("c_i_gnt", o_ig, 1'b0);
    chk("c_addr", o_addr, 8'h10);
    cyc(1'b0, 1'b1, 8'h02, 1'b0, 1'b0, '0, '0, 32'hCAFE_0010);
    chk("c_d_valid", o_dv, 1'b1);
    chk("c_d_rdata", o_drdata, 32'hCAFE_0010);
    chk("c_i_gnt2", o_ig, 1'b1);
    idle(32'hCAFE_0002);
    chk("c_i_valid", o_iv, 1'b1);

    // Data write: completes on grant, no response
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'h04, 32'hDEAD_BEEF, '0);
    chk("w_d_gnt", o_dg, 1'b1);
    chk("w_wren", o_wren, 1'b1);
    idle('0);
    chk("w_d_valid", o_dv, 1'b0);
    chk("w_wren_off", o_wren, 1'b0);

    // Starvation: fetch forced through on the fourth contended cycle
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 8'h80 + 8'(k), '0, 32'(k));
      chk("s_d_gnt", o_dg, (k != 3));
      chk("s_i_gnt", o_ig, (k == 3));
    end
    idle('0);

    // Back-to-back fetches with no bubbles
    for (int k = 0; k < 4; k++) begin
      if (k < 3) cyc(1'b0, 1'b1, 8'(k), 1'b0, 1'b0, '0, '0, 32'h100 + 32'(k));
      else       idle(32'h100 + 32'(k));
      if (k < 3) chk("b_i_gnt", o_ig, 1'b1);
      if (k > 0) chk("b_i_valid", o_iv, 1'b1);
    end

    // Clear after a grant drops the response and the starvation count
    cyc(1'b0, 1'b1, 8'h07, 1'b0, 1'b0, '0, '0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    idle('0);
    chk("clr_i_valid", o_iv, 1'b0);
    // Grant made during the reset cycle gets no response
    cyc(1'b1, 1'b1, 8'h09, 1'b0, 1'b0, '0, '0, '0);
    chk("clr_i_gnt_comb", o_ig, 1'b1);
    idle('0);
    chk("clr_no_valid", o_iv, 1'b0);

    // Randomized traffic obeying the hold-until-granted protocol
    r_ir = 0; r_dr = 0; r_dwe = 0; r_ia = '0; r_da = '0; r_dwd = '0;
    for (int n = 0; n < 400; n++) begin
      bit clr;
      if (!r_ir) begin
        r_ir = ($urandom_range(0, 9) < 7);
        r_ia = AW'($urandom);
      end
      if (!r_dr) begin
        r_dr  = ($urandom_range(0, 9) < 6);
        r_dwe = $urandom_range(0, 1);
        r_da  = AW'($urandom);
        r_dwd = $urandom;
      end
      clr = ($urandom_range(0, 39) == 0);
      cyc(clr, r_ir, r_ia, r_dr, r_dwe, r_da, r_dwd, $urandom);
      if (o_ig || clr) r_ir = 0;
      if (o_dg || clr) r_dr = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DW, 32, data width of the memory word.
REQ-002 Parameter AW, 8, word address width of the memory.
REQ-003 Parameter STARVE_MAX, 3, consecutive denied instruction cycles before instruction is forced to win.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 clear  in  1  reset, synchronous, active-high.
REQ-006 i_req  in  1  instruction-fetch read request; held with i_addr stable until granted.
REQ-007 i_addr  in  AW  instruction word address.
REQ-008 i_gnt  out  1  instruction request accepted this cycle.
REQ-009 i_valid  out  1  i_rdata holds fetched word this cycle.
REQ-010 i_rdata  out  DW  fetched instruction word.
REQ-011 d_req  in  1  data request; held with d_we, d_addr and d_wdata stable until granted.
REQ-012 d_we  in  1  1 = write, 0 = read.
REQ-013 d_addr  in  AW  data word address.
REQ-014 d_wdata  in  DW  write data.
REQ-015 d_gnt  out  1  data request accepted this cycle; a write is complete on this cycle.
REQ-016 d_valid  out  1  d_rdata holds read word this cycle; reads only.
REQ-017 d_rdata  out  DW  data read word.
REQ-018 mem_addr  out  AW  address to the shared single-port RAM.
REQ-019 mem_wren  out  1  RAM write enable.
REQ-020 mem_wdata  out  DW  RAM write data.
REQ-021 mem_rdata  in  DW  RAM registered read data, valid one cycle after the address.

Function
REQ-022 Grant is combinational: force = i_req and starve_cnt == STARVE_MAX; d_gnt = d_req and not force; i_gnt = i_req and not d_gnt.
REQ-023 At most one grant per cycle; a new request may be granted every cycle (fully pipelined, no bubbles).
REQ-024 mem_addr = d_addr when d_gnt, i_addr when i_gnt, 0 otherwise; mem_wren = d_gnt and d_we; mem_wdata = d_wdata always.
REQ-025 Response FSM states IDLE, RD_I, RD_D, registered each cycle: next = RD_D if d_gnt and not d_we; RD_I if i_gnt; IDLE otherwise.
REQ-026 i_valid = (state == RD_I); d_valid = (state == RD_D); read latency is exactly 1 cycle from grant.
REQ-027 i_rdata and d_rdata both pass mem_rdata through; only their valid qualifies them.
REQ-028 starve_cnt (2-bit for default): increments when i_req and not i_gnt, saturates at STARVE_MAX, clears to 0 on i_gnt or when i_req is 0.
REQ-029 A granted data write moves the FSM to IDLE (no response cycle) unless the instruction port is granted in the same cycle, which is impossible per REQ-022.
REQ-030 No requests: no grants, mem_wren = 0, mem_addr = 0, next state IDLE.
REQ-031 Simultaneous i_req and d_req without force: data wins; instruction stalls (i_req and not i_gnt).

Reset
REQ-032 While clear = 1 at a rising edge: state <= IDLE, starve_cnt <= 0; the next cycle shows i_valid = 0 and d_valid = 0.
REQ-033 Reset during an outstanding read drops its response; no valid is issued for a grant made in the reset cycle.
REQ-034 Grants and memory outputs remain combinational during reset; requesters are gated externally by the pipeline clear.

Structure
REQ-035 Shared package mem_arb_pkg holds the state encoding (IDLE = 0, RD_I = 1, RD_D = 2) and the default DW, AW and STARVE_MAX constants.
REQ-036 Single flat module; no sub-module is warranted.

Verification
REQ-037 Reset, then i_req only with i_addr = 0x05 and mem_rdata = 0x00100093 -> i_gnt = 1 in cycle 0; i_valid = 1 with i_rdata = 0x00100093 in cycle 1.
REQ-038 d_req read at 0x10 and i_req at 0x02 in the same cycle -> d_gnt = 1, i_gnt = 0, mem_addr = 0x10; d_valid next cycle; i_gnt the following cycle.
REQ-039 d_req write with addr 0x04 and wdata 0xDEADBEEF -> mem_wren = 1 for one cycle, d_gnt = 1, d_valid never asserted.
REQ-040 d_req and i_req held high for 6 cycles -> d_gnt in cycles 0-2, i_gnt in cycle 3 (starve_cnt = 3), starve_cnt = 0 in cycle 4, d_gnt again in cycle 4.
REQ-041 Back-to-back instruction reads at 0, 1 and 2 -> three consecutive grants and three consecutive i_valid pulses, with no gap.
REQ-042 Assert clear in the cycle after an i_gnt -> i_valid = 0 in the following cycle and starve_cnt = 0.
